// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter: hold, increment or absolute branch load, async clear.
module prog_ctr #(
  parameter int PC_WIDTH = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                BranchEn,
  input  logic                ZeroFlag,
  input  logic [PC_WIDTH-1:0] Target,
  output logic [PC_WIDTH-1:0] ProgCtr
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic                branch_taken;

  assign branch_taken = BranchEn & ZeroFlag;

  // Start gates everything; a not-taken branch falls through to the increment.
  always_comb begin
    pc_d = pc_q;
    if (Start) begin
      if (branch_taken) begin
        pc_d = Target;
      end else begin
        pc_d = pc_q + PC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ProgCtr = pc_q;

endmodule

// File: tb/tb_prog_ctr.sv
// tb/tb_prog_ctr.sv - directed and randomized checks of prog_ctr against a reference model.
module tb_prog_ctr;

  localparam int W = 10;
  localparam int MODV = 1 << W;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         BranchEn;
  logic         ZeroFlag;
  logic [W-1:0] Target;
  logic [W-1:0] ProgCtr;

  int checks;
  int failures;
  int exp_pc;

  prog_ctr #(.PC_WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .BranchEn (BranchEn),
    .ZeroFlag (ZeroFlag),
    .Target   (Target),
    .ProgCtr  (ProgCtr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input int expv);
    logic [W-1:0] e;
    e = W'(expv);
    checks++;
    assert (obs === e)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  // Reference rule applied at each rising edge, written from the behavioural description.
  function automatic int model_next(input int pc, input bit rst, input bit st,
                                    input bit br, input bit zf, input int tgt);
    if (rst)       return 0;
    if (!st)       return pc;
    if (br && zf)  return tgt;
    return (pc + 1) % MODV;
  endfunction

  task automatic edge_check(input string tag, input int expv);
    @(posedge Clk);
    #1;
    check(tag, ProgCtr, expv);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    BranchEn = 1'b0;
    ZeroFlag = 1'b0;
    Target   = '0;

    // Reset with a clock pulse
    edge_check("reset_edge", 0);

    // Hold with Start low
    Reset = 1'b0;
    edge_check("hold_0", 0);
    edge_check("hold_1", 0);
    edge_check("hold_2", 0);
    BranchEn = 1'b1; ZeroFlag = 1'b1; Target = W'(100);
    edge_check("hold_branch_ignored", 0);

    // Increment
    BranchEn = 1'b0; ZeroFlag = 1'b0; Start = 1'b1;
    edge_check("inc_1", 1);
    edge_check("inc_2", 2);

    // Taken branch then increment
    BranchEn = 1'b1; ZeroFlag = 1'b1; Target = W'(100);
    edge_check("branch_taken", 100);
    BranchEn = 1'b0;
    edge_check("post_branch_inc", 101);

    // Not-taken branch, then flag alone
    BranchEn = 1'b1; ZeroFlag = 1'b0; Target = W'(7);
    edge_check("branch_not_taken", 102);
    BranchEn = 1'b0; ZeroFlag = 1'b1;
    edge_check("flag_only", 103);

    // Wrap-around
    BranchEn = 1'b1; ZeroFlag = 1'b1; Target = W'(MODV - 1);
    edge_check("branch_top", MODV - 1);
    BranchEn = 1'b0; ZeroFlag = 1'b0;
    edge_check("wrap_0", 0);
    edge_check("wrap_1", 1);

    // Branch to current PC and to 0
    BranchEn = 1'b1; ZeroFlag = 1'b1; Target = W'(1);
    edge_check("branch_self", 1);
    Target = '0;
    edge_check("branch_zero", 0);
    BranchEn = 1'b0; ZeroFlag = 1'b0;
    edge_check("inc_after_zero", 1);
    edge_check("inc_to_5a", 2);
    edge_check("inc_to_5b", 3);
    edge_check("inc_to_5c", 4);
    edge_check("inc_to_5d", 5);

    // Asynchronous reset between edges at PC=5
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("async_reset_immediate", ProgCtr, 0);
    edge_check("reset_held", 0);
    @(negedge Clk);
    Reset = 1'b0;
    edge_check("first_edge_after_reset", 1);

    // Randomized phase against the reference model
    exp_pc = 1;
    for (int i = 0; i < 400; i++) begin
      bit rst_now;
      @(negedge Clk);
      rst_now  = ($urandom_range(0, 19) == 0);
      Start    = 1'($urandom_range(0, 3) != 0);
      BranchEn = 1'($urandom);
      ZeroFlag = 1'($urandom);
      Target   = ($urandom_range(0, 7) == 0) ? W'(MODV - 1) : W'($urandom);
      Reset    = rst_now;
      if (rst_now) begin
        exp_pc = 0;
        #1;
        check("rand_async_reset", ProgCtr, 0);
      end
      exp_pc = model_next(exp_pc, rst_now, Start, BranchEn, ZeroFlag, int'(Target));
      edge_check("rand_step", exp_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
